// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Round-robin sequencer that time-shares one serial signed multiplier
//   (start/rdy handshake) between NUM_REQ requesters. One operation runs at a
//   time: grant + operand capture, start pulse, wait for rdy, return product.
//   Optional macro MUL_ARB_TIMEOUT_EN adds a watchdog on the rdy wait that
//   aborts the operation with an err_o pulse after TIMEOUT cycles.
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*WIDTH_A-1:0]   A_i,
  input  logic [NUM_REQ*WIDTH_B-1:0]   B_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [WIDTH_A+WIDTH_B-1:0]   Y_o,
  output logic [NUM_REQ-1:0]           valid_o,
  output logic                         err_o,
  output logic                         busy_o,
  output logic                         mul_start_o,
  output logic [WIDTH_A-1:0]           mul_A_o,
  output logic [WIDTH_B-1:0]           mul_B_o,
  input  logic [WIDTH_A+WIDTH_B-1:0]   mul_Y_i,
  input  logic                         mul_rdy_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [IDX_W:0]   cand;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err_o = 1'b0;
`endif

  // Pointer moves just past whoever was served (or aborted), wrapping.
  assign ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Pick the first asserted request at or after rr_ptr; scanning offsets from
  // high to low lets the smallest offset win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) cand = cand - (IDX_W + 1)'(NUM_REQ);
      if (req_i[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Sequencer FSM; every output is registered here so pulses are glitch-free.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      gnt_o       <= '0;
      valid_o     <= '0;
      busy_o      <= 1'b0;
      mul_start_o <= 1'b0;
      Y_o         <= '0;
      mul_A_o     <= '0;
      mul_B_o     <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      err_o       <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      valid_o     <= '0;
      mul_start_o <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      err_o       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt_o       <= NUM_REQ'(1) << sel_idx;
            gnt_idx     <= sel_idx;
            mul_A_o     <= A_i[sel_idx*WIDTH_A +: WIDTH_A];
            mul_B_o     <= B_i[sel_idx*WIDTH_B +: WIDTH_B];
            mul_start_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= START;
`ifdef MUL_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end
        START: begin
          // The start cycle counts toward the watchdog window.
          state <= WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
        end
        WAIT: begin
          if (mul_rdy_i) begin
            Y_o     <= mul_Y_i;
            valid_o <= gnt_o;
            gnt_o   <= '0;
            rr_ptr  <= ptr_nxt;
            state   <= DONE;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            err_o  <= 1'b1;
            gnt_o  <= '0;
            rr_ptr <= ptr_nxt;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
